// File: rtl/jzjpcc_muldiv_sequencer.sv
// RV32M multiply/divide sequencer: iterative shift-add multiply and restoring divide.
// Stalls the pipeline for N = 32/ITER_BITS cycles, then presents the result for one cycle.
module jzjpcc_muldiv_sequencer #(
  parameter int ITER_BITS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  localparam int N  = 32 / ITER_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [63:0]   acc_q, acc_d;
  logic [32:0]   rem_q, rem_d;
  logic [31:0]   opb_q, opb_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   result_q, result_d;

  logic        is_div, sgn_a, sgn_b, neg_a, neg_b, res_neg, div_zero, div_ovf;
  logic [31:0] mag_a, mag_b;
  logic [63:0] mul_acc, mul_signed;
  logic [32:0] mul_sum, div_rem;
  logic [31:0] div_quo, div_val, div_signed, calc_result;

  // MUL is treated as signed*signed; its low word is identical either way.
  assign is_div   = funct3[2];
  assign sgn_a    = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign sgn_b    = is_div ? ~funct3[0] : ~funct3[1];
  assign neg_a    = sgn_a & rs1[31];
  assign neg_b    = sgn_b & rs2[31];
  assign mag_a    = neg_a ? (~rs1 + 32'd1) : rs1;
  assign mag_b    = neg_b ? (~rs2 + 32'd1) : rs2;
  assign res_neg  = (is_div & funct3[1]) ? neg_a : (neg_a ^ neg_b);
  assign div_zero = is_div & (rs2 == 32'd0);
  assign div_ovf  = is_div & ~funct3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right per bit.
    mul_sum = '0;
    mul_acc = acc_q;
    for (int i = 0; i < ITER_BITS; i++) begin
      mul_sum = {1'b0, mul_acc[63:32]} + (mul_acc[0] ? {1'b0, opb_q} : 33'd0);
      mul_acc = {mul_sum, mul_acc[31:1]};
    end

    // Divide: dividend bits shift out of acc[31:0] while quotient bits shift in.
    div_rem = rem_q;
    div_quo = acc_q[31:0];
    for (int i = 0; i < ITER_BITS; i++) begin
      div_rem = {div_rem[31:0], div_quo[31]};
      div_quo = {div_quo[30:0], 1'b0};
      if (div_rem >= {1'b0, opb_q}) begin
        div_rem    = div_rem - {1'b0, opb_q};
        div_quo[0] = 1'b1;
      end
    end

    mul_signed  = neg_q ? (~mul_acc + 64'd1) : mul_acc;
    div_val     = op_q[1] ? div_rem[31:0] : div_quo;
    div_signed  = neg_q ? (~div_val + 32'd1) : div_val;
    calc_result = op_q[2] ? div_signed
                : ((op_q[1:0] == 2'b00) ? mul_signed[31:0] : mul_signed[63:32]);

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d  = funct3;
          neg_d = res_neg;
          opb_d = mag_b;
          cnt_d = '0;
          acc_d = {32'd0, mag_a};
          rem_d = '0;
          if (div_zero) begin
            result_d = funct3[1] ? rs1 : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? {32'd0, div_quo} : mul_acc;
          if (op_q[2]) rem_d = div_rem;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            result_d = calc_result;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // A squashed instruction must never hand a result to the memory stage.
  assign done   = (state_q == S_DONE) & ~flush;
  assign stall  = ~reset & (((state_q == S_IDLE) & start & ~flush) | (state_q == S_CALC));
  assign result = result_q;

endmodule
